// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/almost-empty flags,
// sticky overflow/underflow flags and a synchronous flush.
module fifo_sync_param #(
  parameter  int WIDTH    = 3,
  parameter  int DEPTH    = 5,
  parameter  int AF_LEVEL = 4,
  parameter  int AE_LEVEL = 1,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr,
  input  logic [WIDTH-1:0] datin,
  input  logic             rd,
  output logic [WIDTH-1:0] datout,
  output logic             dato,
  output logic             full,
  output logic             empy,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             ovf,
  output logic             udf
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             rd_acc;
  logic             wr_acc;

  // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1))
      next_ptr = '0;
    else
      next_ptr = p + 1'b1;
  endfunction

  function automatic logic [CW-1:0] next_count(input logic [CW-1:0] c,
                                               input logic          inc,
                                               input logic          dec);
    next_count = c;
    if (inc && !dec)
      next_count = c + 1'b1;
    else if (dec && !inc)
      next_count = c - 1'b1;
  endfunction

  assign empy         = (count == '0);
  assign full         = (count == CW'(DEPTH));
  assign almost_full  = (count >= CW'(AF_LEVEL));
  assign almost_empty = (count <= CW'(AE_LEVEL));

  // A full FIFO still accepts a write when a read frees a slot on the same edge.
  assign rd_acc = rd & ~empy;
  assign wr_acc = wr & (~full | rd_acc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      datout <= '0;
      dato   <= 1'b0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else if (clr) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      datout <= '0;
      dato   <= 1'b0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      if (wr_acc)
        wptr <= next_ptr(wptr);
      if (rd_acc) begin
        rptr   <= next_ptr(rptr);
        datout <= mem[rptr];
      end
      dato  <= rd_acc;
      count <= next_count(count, wr_acc, rd_acc);
      ovf   <= ovf | (wr & ~wr_acc);
      udf   <= udf | (rd & ~rd_acc);
    end
  end

  // Storage is never reset; a same-slot read on this edge still sees the old word.
  always_ff @(posedge clk) begin
    if (!rst && !clr && wr_acc)
      mem[wptr] <= datin;
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed self-checking bench for fifo_sync_param with default parameters (3 bits x 5 entries).
module tb_fifo_sync_param;

  localparam int WIDTH = 3;
  localparam int DEPTH = 5;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             clr;
  logic             wr;
  logic [WIDTH-1:0] datin;
  logic             rd;
  logic [WIDTH-1:0] datout;
  logic             dato;
  logic             full;
  logic             empy;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             ovf;
  logic             udf;

  int total = 0;
  int bad   = 0;

  fifo_sync_param #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(4), .AE_LEVEL(1)
  ) dut (
    .clk(clk), .rst(rst), .clr(clr), .wr(wr), .datin(datin), .rd(rd),
    .datout(datout), .dato(dato), .full(full), .empy(empy),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [WIDTH-1:0] v);
    wr = 1'b1; datin = v; rd = 1'b0;
    cyc();
    wr = 1'b0;
  endtask

  task automatic get(input logic [WIDTH-1:0] v, input string tag);
    rd = 1'b1; wr = 1'b0;
    cyc();
    rd = 1'b0;
    chk({tag, "_data"}, datout, v);
    chk({tag, "_dato"}, dato, 1);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; wr = 1'b0; rd = 1'b0; datin = '0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_empy", empy, 1);
    chk("rst_full", full, 0);
    chk("rst_ae", almost_empty, 1);
    chk("rst_af", almost_full, 0);
    chk("rst_datout", datout, 0);
    chk("rst_dato", dato, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_udf", udf, 0);
    cyc(); cyc();
    rst = 1'b0;
    cyc();

    // fill
    for (int i = 1; i <= 5; i++) begin
      put(WIDTH'(i));
      chk("fill_count", count, i);
      chk("fill_af", almost_full, (i >= 4) ? 1 : 0);
      chk("fill_full", full, (i == 5) ? 1 : 0);
      chk("fill_ae", almost_empty, (i <= 1) ? 1 : 0);
      chk("fill_empy", empy, 0);
    end
    put(3'd6);
    chk("ovf_set", ovf, 1);
    chk("ovf_count", count, 5);
    chk("ovf_udf", udf, 0);

    // drain
    for (int i = 1; i <= 5; i++) begin
      get(WIDTH'(i), "drain");
      chk("drain_count", count, 5 - i);
    end
    chk("drain_empy", empy, 1);
    rd = 1'b1;
    cyc();
    rd = 1'b0;
    chk("udf_set", udf, 1);
    chk("udf_datout_hold", datout, 5);
    chk("udf_dato", dato, 0);
    cyc();
    chk("idle_dato", dato, 0);
    chk("idle_datout", datout, 5);

    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("clr1_ovf", ovf, 0);
    chk("clr1_udf", udf, 0);
    chk("clr1_datout", datout, 0);

    // wrap: 3 in/out, then 5 in/out crossing slot DEPTH-1
    put(3'd1); put(3'd2); put(3'd3);
    get(3'd1, "wrapA"); get(3'd2, "wrapA"); get(3'd3, "wrapA");
    put(3'd4); put(3'd5); put(3'd6); put(3'd7); put(3'd0);
    chk("wrap_full", full, 1);
    get(3'd4, "wrapB"); get(3'd5, "wrapB"); get(3'd6, "wrapB");
    get(3'd7, "wrapB"); get(3'd0, "wrapB");
    chk("wrap_empy", empy, 1);
    chk("wrap_ovf", ovf, 0);
    chk("wrap_udf", udf, 0);

    // simultaneous read/write when full
    put(3'd1); put(3'd2); put(3'd3); put(3'd4); put(3'd5);
    wr = 1'b1; rd = 1'b1; datin = 3'd7;
    cyc();
    wr = 1'b0; rd = 1'b0;
    chk("simf_datout", datout, 1);
    chk("simf_dato", dato, 1);
    chk("simf_count", count, 5);
    chk("simf_ovf", ovf, 0);
    get(3'd2, "simf_drain"); get(3'd3, "simf_drain"); get(3'd4, "simf_drain");
    get(3'd5, "simf_drain"); get(3'd7, "simf_drain");
    chk("simf_empy", empy, 1);

    // simultaneous read/write when empty: no fall-through
    wr = 1'b1; rd = 1'b1; datin = 3'd6;
    cyc();
    wr = 1'b0; rd = 1'b0;
    chk("sime_count", count, 1);
    chk("sime_udf", udf, 1);
    chk("sime_dato", dato, 0);
    chk("sime_datout", datout, 7);
    get(3'd6, "sime_read");

    // flush with a concurrent write
    put(3'd1); put(3'd2); put(3'd3);
    chk("pre_clr_count", count, 3);
    clr = 1'b1; wr = 1'b1; datin = 3'd5;
    cyc();
    clr = 1'b0; wr = 1'b0;
    chk("clr_count", count, 0);
    chk("clr_empy", empy, 1);
    chk("clr_ovf", ovf, 0);
    chk("clr_udf", udf, 0);
    cyc();
    chk("clr_count_hold", count, 0);
    put(3'd2);
    get(3'd2, "post_clr");

    // async reset mid-stream
    put(3'd3); put(3'd4); put(3'd5); put(3'd6);
    rd = 1'b1;
    cyc();
    rd = 1'b0;
    chk("mid_count", count, 3);
    chk("mid_datout", datout, 3);
    chk("mid_dato", dato, 1);
    rst = 1'b1;
    #1;
    chk("arst_count", count, 0);
    chk("arst_empy", empy, 1);
    chk("arst_datout", datout, 0);
    chk("arst_dato", dato, 0);
    cyc();
    rst = 1'b0;
    cyc();
    chk("arst_after_count", count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
